// File: rtl/spi_frame_sender.sv
// ---------------------------------------------------------------------------
// spi_frame_sender
//
// SPI master that streams a complete framebuffer to a display controller.
// For each row it opens one ss frame carrying the command byte 0xF0|row,
// followed by COLUMNS pixels of three bytes each ({R,G,B}, MSB first). After
// the last row it sends a separate ss frame carrying the load command 0x10.
// Pixels come from a local framebuffer RAM with a one-cycle read latency.
//
// Parameters
//   ROWS      framebuffer rows (<= 16, row index fits the command nibble)
//   COLUMNS   pixels per row (<= 256)
//   BITWIDTH  bits per colour channel; the top 8 bits of a channel form its byte
//   CLKDIV    clk cycles per sclk half-period (>= 1)
//   GAP       clk cycles ss stays low between frames (>= 1)
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     request one full transfer; sampled only while idle
//   row_mask_i  (SPI_FRAME_SENDER_PARTIAL_EN only) per-row enable, latched on start
//   busy_o      high from the cycle after start is accepted until done
//   done_o      one-cycle pulse when the transfer completes
//   ren_o       framebuffer read strobe (one-cycle pulse)
//   rrow_o      framebuffer read row
//   rcol_o      framebuffer read column
//   rdata_i     pixel {R,G,B}, valid the cycle after ren_o
//   sclk_o      SPI clock, idles low
//   ss_o        frame select, active high
//   mosi_o      SPI data, changes only together with a falling sclk or while low
//
// Build option
//   SPI_FRAME_SENDER_PARTIAL_EN : adds row_mask_i; rows with a 0 mask bit are
//   skipped entirely (no frame, no reads). The load frame is always sent.
// ---------------------------------------------------------------------------
module spi_frame_sender #(
   parameter int ROWS     = 8,
   parameter int COLUMNS  = 32,
   parameter int BITWIDTH = 8,
   parameter int CLKDIV   = 2,
   parameter int GAP      = 4,
   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int COL_W   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
`ifdef SPI_FRAME_SENDER_PARTIAL_EN
   input  logic [ROWS-1:0]       row_mask_i,
`endif
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ren_o,
   output logic [ROW_W-1:0]      rrow_o,
   output logic [COL_W-1:0]      rcol_o,
   input  logic [3*BITWIDTH-1:0] rdata_i,
   output logic                  sclk_o,
   output logic                  ss_o,
   output logic                  mosi_o
);

   localparam int CNT_MAX = (CLKDIV > GAP) ? CLKDIV : GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ROW_START, S_LOAD_START, S_BIT_LOW, S_BIT_HIGH, S_FETCH,
      S_READ, S_LATCH, S_TAIL, S_ROW_GAP, S_LOAD_GAP, S_DONE
   } state_e;

   // What the byte currently on the wire belongs to; decides where to go
   // once its last bit has been clocked out.
   typedef enum logic [1:0] {K_CMD, K_PIXEL, K_LOAD} kind_e;

   state_e               state_q;
   kind_e                kind_q;
   logic [ROW_W-1:0]     row_q, rrow_q;
   logic [COL_W-1:0]     col_q, rcol_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2:0]           bit_q;
   logic [1:0]           byte_q;
   logic [6:0]           shreg_q;      // bits still to send after the one on mosi
   logic [3*BITWIDTH-1:0] pixel_q;
   logic                 ss_q, sclk_q, mosi_q, busy_q, done_q, ren_q;

   logic                 row_en;
   logic                 phase_end, gap_end, last_row, last_col;
   logic [7:0]           first_chan, next_chan;

   function automatic logic [7:0] chan_byte(input logic [3*BITWIDTH-1:0] pix,
                                            input logic [1:0] idx);
      case (idx)
         2'd0:    return pix[3*BITWIDTH-1 -: 8];
         2'd1:    return pix[2*BITWIDTH-1 -: 8];
         default: return pix[BITWIDTH-1 -: 8];
      endcase
   endfunction

`ifdef SPI_FRAME_SENDER_PARTIAL_EN
   logic [ROWS-1:0] mask_q;
   assign row_en = mask_q[row_q];
`else
   assign row_en = 1'b1;
`endif

   assign phase_end  = (cnt_q == CNT_W'(CLKDIV - 1));
   assign gap_end    = (cnt_q == CNT_W'(GAP - 1));
   assign last_row   = (row_q == ROW_W'(ROWS - 1));
   assign last_col   = (col_q == COL_W'(COLUMNS - 1));
   assign first_chan = chan_byte(rdata_i, 2'd0);
   assign next_chan  = chan_byte(pixel_q, byte_q + 2'd1);

   // NOTE: every register here is updated with <= so all branches see the
   // values from the start of the cycle, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         kind_q  <= K_CMD;
         row_q   <= '0;
         col_q   <= '0;
         rrow_q  <= '0;
         rcol_q  <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shreg_q <= '0;
         pixel_q <= '0;
         ss_q    <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ren_q   <= 1'b0;
`ifdef SPI_FRAME_SENDER_PARTIAL_EN
         mask_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               busy_q  <= 1'b1;
               row_q   <= '0;
               state_q <= S_ROW_START;
`ifdef SPI_FRAME_SENDER_PARTIAL_EN
               mask_q  <= row_mask_i;
`endif
            end
            // Masked rows are skipped one per cycle; ss stays low meanwhile.
            S_ROW_START: begin
               if (row_en) begin
                  ss_q    <= 1'b1;
                  mosi_q  <= 1'b1;
                  shreg_q <= {3'b111, 4'(row_q)};
                  kind_q  <= K_CMD;
                  bit_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_BIT_LOW;
               end else if (last_row) begin
                  state_q <= S_LOAD_START;
               end else begin
                  row_q   <= row_q + ROW_W'(1);
               end
            end
            S_LOAD_START: begin
               ss_q    <= 1'b1;
               mosi_q  <= 1'b0;
               shreg_q <= 7'b0010000;
               kind_q  <= K_LOAD;
               row_q   <= '0;
               bit_q   <= '0;
               cnt_q   <= '0;
               state_q <= S_BIT_LOW;
            end
            // For the first bit of a frame this low phase doubles as the
            // ss-to-first-rise setup time.
            S_BIT_LOW: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (phase_end) begin
                  sclk_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_BIT_HIGH;
               end
            end
            S_BIT_HIGH: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (phase_end) begin
                  sclk_q <= 1'b0;
                  cnt_q  <= '0;
                  if (bit_q != 3'd7) begin
                     mosi_q  <= shreg_q[6];
                     shreg_q <= {shreg_q[5:0], 1'b0};
                     bit_q   <= bit_q + 3'd1;
                     state_q <= S_BIT_LOW;
                  end else begin
                     bit_q <= '0;
                     case (kind_q)
                        K_CMD: begin
                           col_q   <= '0;
                           state_q <= S_FETCH;
                        end
                        K_PIXEL: begin
                           if (byte_q != 2'd2) begin
                              byte_q  <= byte_q + 2'd1;
                              mosi_q  <= next_chan[7];
                              shreg_q <= next_chan[6:0];
                              state_q <= S_BIT_LOW;
                           end else if (!last_col) begin
                              col_q   <= col_q + COL_W'(1);
                              state_q <= S_FETCH;
                           end else begin
                              state_q <= S_TAIL;
                           end
                        end
                        default: state_q <= S_TAIL;
                     endcase
                  end
               end
            end
            S_FETCH: begin
               ren_q   <= 1'b1;
               rrow_q  <= row_q;
               rcol_q  <= col_q;
               kind_q  <= K_PIXEL;
               state_q <= S_READ;
            end
            S_READ: begin
               ren_q   <= 1'b0;
               state_q <= S_LATCH;
            end
            S_LATCH: begin
               pixel_q <= rdata_i;
               byte_q  <= '0;
               mosi_q  <= first_chan[7];
               shreg_q <= first_chan[6:0];
               cnt_q   <= '0;
               state_q <= S_BIT_LOW;
            end
            S_TAIL: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (phase_end) begin
                  ss_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= (kind_q == K_LOAD) ? S_LOAD_GAP : S_ROW_GAP;
               end
            end
            S_ROW_GAP: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (gap_end) begin
                  cnt_q <= '0;
                  if (last_row) begin
                     state_q <= S_LOAD_START;
                  end else begin
                     row_q   <= row_q + ROW_W'(1);
                     state_q <= S_ROW_START;
                  end
               end
            end
            S_LOAD_GAP: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (gap_end) begin
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign ren_o  = ren_q;
   assign rrow_o = rrow_q;
   assign rcol_o = rcol_q;
   assign sclk_o = sclk_q;
   assign ss_o   = ss_q;
   assign mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_frame_sender.sv
// Bench for spi_frame_sender. Two instances share one framebuffer model and
// one SPI monitor (a select picks the active one): dut1 uses the default
// geometry and timing, dut2 a small 4x4 framebuffer with CLKDIV=3, GAP=5.
// The monitor decodes SPI frames into bytes and counts timing violations;
// expected streams are built from the framebuffer contents and frame rules.
module tb_spi_frame_sender;

   localparam int R1 = 8, C1 = 32, D1 = 2, G1 = 4;
   localparam int R2 = 4, C2 = 4, D2 = 3, G2 = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic start1 = 1'b0, start2 = 1'b0;
   logic busy1, done1, ren1, sclk1, ss1, mosi1;
   logic busy2, done2, ren2, sclk2, ss2, mosi2;
   logic [2:0] rrow1;
   logic [4:0] rcol1;
   logic [1:0] rrow2, rcol2;
   logic [23:0] rdata = '0;
`ifdef SPI_FRAME_SENDER_PARTIAL_EN
   logic [7:0] mask1 = 8'hFF;
   logic [3:0] mask2 = 4'hF;
`endif

   spi_frame_sender #(.ROWS(R1), .COLUMNS(C1), .BITWIDTH(8), .CLKDIV(D1), .GAP(G1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start1),
`ifdef SPI_FRAME_SENDER_PARTIAL_EN
      .row_mask_i(mask1),
`endif
      .busy_o(busy1), .done_o(done1), .ren_o(ren1), .rrow_o(rrow1), .rcol_o(rcol1),
      .rdata_i(rdata), .sclk_o(sclk1), .ss_o(ss1), .mosi_o(mosi1));

   spi_frame_sender #(.ROWS(R2), .COLUMNS(C2), .BITWIDTH(8), .CLKDIV(D2), .GAP(G2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start2),
`ifdef SPI_FRAME_SENDER_PARTIAL_EN
      .row_mask_i(mask2),
`endif
      .busy_o(busy2), .done_o(done2), .ren_o(ren2), .rrow_o(rrow2), .rcol_o(rcol2),
      .rdata_i(rdata), .sclk_o(sclk2), .ss_o(ss2), .mosi_o(mosi2));

   // ---------------- active-instance select ----------------
   bit sel = 1'b0;
   int cur_div = D1, cur_gap = G1;
   logic m_ss, m_sclk, m_mosi, m_busy, m_done, m_ren;
   int m_row, m_col;
   assign m_ss   = sel ? ss2   : ss1;
   assign m_sclk = sel ? sclk2 : sclk1;
   assign m_mosi = sel ? mosi2 : mosi1;
   assign m_busy = sel ? busy2 : busy1;
   assign m_done = sel ? done2 : done1;
   assign m_ren  = sel ? ren2  : ren1;
   assign m_row  = sel ? int'(rrow2) : int'(rrow1);
   assign m_col  = sel ? int'(rcol2) : int'(rcol1);

   // ---------------- framebuffer model ----------------
   logic [23:0] fb [0:7][0:31];
   bit rd_pend = 1'b0;
   int rd_r = 0, rd_c = 0;

   initial forever begin
      @(posedge clk);
      if (rd_pend) begin
         rdata <= fb[rd_r][rd_c];
         rd_pend = 1'b0;
      end
   end

   // ---------------- SPI monitor ----------------
   int rx_bytes[$], rx_len[$], reads[$];
   int exp_bytes[$], exp_len[$], exp_reads[$];
   int rises = 0, dones = 0, cur_len = 0, bitcnt = 0;
   int lo_run = 0, hi_run = 0, gap_run = 1000;
   int v_hi = 0, v_lo = 0, v_mosi = 0, v_tail = 0, v_gap = 0, v_ren = 0;
   int v_align = 0, v_nss = 0, v_busy = 0;
   logic [7:0] cur_byte = '0;
   logic p_ss = 1'b0, p_sclk = 1'b0, p_mosi = 1'b0, p_ren = 1'b0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         // A frame cut by reset is discarded, as the receiver would do.
         while (cur_len > 0) begin
            void'(rx_bytes.pop_back());
            cur_len--;
         end
         bitcnt = 0; lo_run = 0; hi_run = 0; gap_run = 1000;
         p_ss = 1'b0; p_sclk = 1'b0; p_mosi = 1'b0; p_ren = 1'b0; rd_pend = 1'b0;
      end else begin
         if (m_ren) begin
            if (p_ren) v_ren++;
            reads.push_back(m_row * 256 + m_col);
            rd_r = m_row; rd_c = m_col; rd_pend = 1'b1;
         end
         if (m_done) begin
            dones++;
            if (m_busy) v_busy++;
         end
         if (m_ss && !m_busy) v_busy++;
         if (m_ss && !p_ss) begin
            if (gap_run < cur_gap) v_gap++;
            lo_run = 0; cur_len = 0; bitcnt = 0;
         end
         if (m_ss) begin
            if (m_sclk && !p_sclk) begin
               if (bitcnt == 0 ? (lo_run < cur_div) : (lo_run != cur_div)) v_lo++;
               if (m_mosi !== p_mosi) v_mosi++;
               cur_byte = {cur_byte[6:0], m_mosi};
               bitcnt++; rises++; hi_run = 1;
               if (bitcnt == 8) begin
                  rx_bytes.push_back(int'(cur_byte));
                  cur_len++; bitcnt = 0;
               end
            end else if (!m_sclk && p_sclk) begin
               if (hi_run != cur_div) v_hi++;
               lo_run = 1;
            end else if (m_sclk) begin
               hi_run++;
            end else begin
               lo_run++;
            end
         end else begin
            if (m_sclk) v_nss++;
            if (p_ss) begin
               if (p_sclk || lo_run < cur_div) v_tail++;
               if (bitcnt != 0) v_align++;
               rx_len.push_back(cur_len);
               cur_len = 0; gap_run = 0;
            end
            gap_run++;
         end
         p_ss = m_ss; p_sclk = m_sclk; p_mosi = m_mosi; p_ren = m_ren;
      end
   end

   // ---------------- reference model ----------------
   int checks = 0, errors = 0;

   task automatic fill_fb(input bit pattern);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 32; c++)
            fb[r][c] = pattern ? {r[7:0], 8'hED, c[7:0]} : 24'($urandom);
   endtask

   // One frame per enabled row (command + 3 bytes per pixel), then the load frame.
   task automatic build_expected(input int rows, input int cols, input logic [7:0] mask);
      for (int r = 0; r < rows; r++) begin
         if (mask[r]) begin
            exp_len.push_back(1 + 3 * cols);
            exp_bytes.push_back(8'hF0 | r);
            for (int c = 0; c < cols; c++) begin
               exp_bytes.push_back(int'(fb[r][c][23:16]));
               exp_bytes.push_back(int'(fb[r][c][15:8]));
               exp_bytes.push_back(int'(fb[r][c][7:0]));
               exp_reads.push_back(r * 256 + c);
            end
         end
      end
      exp_len.push_back(1);
      exp_bytes.push_back(8'h10);
   endtask

   function automatic int first_diff(input int a[$], input int b[$]);
      for (int i = 0; i < b.size(); i++)
         if (i >= a.size() || a[i] != b[i]) return i;
      if (a.size() != b.size()) return b.size();
      return -1;
   endfunction

   function automatic int viol_total();
      return v_hi + v_lo + v_mosi + v_tail + v_gap + v_ren + v_align + v_nss + v_busy;
   endfunction

   task automatic clear_obs();
      rx_bytes.delete(); rx_len.delete(); reads.delete();
      exp_bytes.delete(); exp_len.delete(); exp_reads.delete();
      rises = 0; dones = 0;
      v_hi = 0; v_lo = 0; v_mosi = 0; v_tail = 0; v_gap = 0; v_ren = 0;
      v_align = 0; v_nss = 0; v_busy = 0;
   endtask

   task automatic use_dut(input bit which);
      sel = which;
      cur_div = which ? D2 : D1;
      cur_gap = which ? G2 : G1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (m_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({ss1, sclk1, mosi1, busy1, done1, ren1, rrow1, rcol1} !== '0) begin
         errors++;
         $display("FAIL reset_dut1 got %b want 0", {ss1, sclk1, mosi1, busy1, done1, ren1, rrow1, rcol1});
      end
      checks++;
      if ({ss2, sclk2, mosi2, busy2, done2, ren2, rrow2, rcol2} !== '0) begin
         errors++;
         $display("FAIL reset_dut2 got %b want 0", {ss2, sclk2, mosi2, busy2, done2, ren2, rrow2, rcol2});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full_frame();
      bit ok;
      int d;
      use_dut(1'b0);
      fill_fb(1'b1);
      clear_obs();
      build_expected(R1, C1, 8'hFF);
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("FAIL full_busy_after_start got %b want 1", busy1);
      end
      wait_done(40000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL full_done_timeout got no done want done");
      end
      repeat (4) @(negedge clk);
      checks++;
      if (rx_len.size() !== 9) begin
         errors++;
         $display("FAIL full_frame_count got %0d want 9", rx_len.size());
      end
      d = first_diff(rx_bytes, exp_bytes);
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL full_bytes first diff at %0d got %0d want %0d", d,
                  (d < rx_bytes.size()) ? rx_bytes[d] : -1, (d < exp_bytes.size()) ? exp_bytes[d] : -1);
      end
      d = first_diff(rx_len, exp_len);
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL full_frame_len first diff at frame %0d", d);
      end
      checks++;
      if (rises !== 6216) begin
         errors++;
         $display("FAIL full_sclk_rises got %0d want 6216", rises);
      end
      d = first_diff(reads, exp_reads);
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL full_reads first diff at %0d got %0d reads want %0d", d, reads.size(), exp_reads.size());
      end
      checks++;
      if (dones !== 1 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL full_done_busy got dones=%0d busy=%b want 1/0", dones, busy1);
      end
      checks++;
      if ({rrow1, rcol1} !== {3'd7, 5'd31}) begin
         errors++;
         $display("FAIL full_raddr_hold got %0d/%0d want 7/31", rrow1, rcol1);
      end
      checks++;
      if (viol_total() !== 0) begin
         errors++;
         $display("FAIL full_timing got hi=%0d lo=%0d mosi=%0d tail=%0d gap=%0d ren=%0d align=%0d nss=%0d busy=%0d want 0",
                  v_hi, v_lo, v_mosi, v_tail, v_gap, v_ren, v_align, v_nss, v_busy);
      end
   endtask

   task automatic test_timing();
      bit ok;
      int d;
      use_dut(1'b1);
      fill_fb(1'b0);
      clear_obs();
      build_expected(R2, C2, 8'hFF);
      pulse_start();
      wait_done(10000, ok);
      repeat (4) @(negedge clk);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timing_done_timeout got no done want done");
      end
      d = first_diff(rx_bytes, exp_bytes);
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL timing_bytes first diff at %0d got %0d bytes want %0d", d, rx_bytes.size(), exp_bytes.size());
      end
      checks++;
      if (viol_total() !== 0) begin
         errors++;
         $display("FAIL timing_phases got hi=%0d lo=%0d mosi=%0d tail=%0d gap=%0d ren=%0d want 0",
                  v_hi, v_lo, v_mosi, v_tail, v_gap, v_ren);
      end
      checks++;
      if (rises !== 8 * exp_bytes.size()) begin
         errors++;
         $display("FAIL timing_rises got %0d want %0d", rises, 8 * exp_bytes.size());
      end
   endtask

   task automatic test_start_held();
      bit ok;
      use_dut(1'b1);
      fill_fb(1'b0);
      clear_obs();
      build_expected(R2, C2, 8'hFF);
      @(negedge clk);
      start2 = 1'b1;
      wait_done(10000, ok);
      start2 = 1'b0;
      repeat (300) @(negedge clk);
      checks++;
      if (!ok || dones !== 1 || rx_len.size() !== exp_len.size()) begin
         errors++;
         $display("FAIL start_held got ok=%0d dones=%0d frames=%0d want 1/1/%0d", ok, dones, rx_len.size(), exp_len.size());
      end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      int d;
      use_dut(1'b1);
      fill_fb(1'b0);
      clear_obs();
      build_expected(R2, C2, 8'hFF);
      build_expected(R2, C2, 8'hFF);
      pulse_start();
      wait_done(10000, ok1);
      pulse_start();
      wait_done(10000, ok2);
      repeat (4) @(negedge clk);
      d = first_diff(rx_bytes, exp_bytes);
      checks++;
      if (!ok1 || !ok2 || d !== -1 || dones !== 2) begin
         errors++;
         $display("FAIL back_to_back got ok=%0d%0d diff=%0d dones=%0d want 11/-1/2", ok1, ok2, d, dones);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, reached;
      int d;
      use_dut(1'b1);
      fill_fb(1'b0);
      clear_obs();
      pulse_start();
      reached = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (rx_len.size() == 3 && m_ss && bitcnt == 3) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("FAIL reset_mid_reach got no row3 byte want row3 mid-byte");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ss2, sclk2, mosi2, busy2} !== 4'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs got %b want 0000", {ss2, sclk2, mosi2, busy2});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (rx_len.size() !== 3 || dones !== 0) begin
         errors++;
         $display("FAIL reset_mid_no_load got frames=%0d dones=%0d want 3/0", rx_len.size(), dones);
      end
      rst_n = 1'b1;
      @(negedge clk);
      clear_obs();
      build_expected(R2, C2, 8'hFF);
      pulse_start();
      wait_done(10000, ok);
      repeat (4) @(negedge clk);
      d = first_diff(rx_bytes, exp_bytes);
      checks++;
      if (!ok || d !== -1 || viol_total() !== 0) begin
         errors++;
         $display("FAIL reset_mid_recover got ok=%0d diff=%0d viol=%0d want 1/-1/0", ok, d, viol_total());
      end
   endtask

`ifdef SPI_FRAME_SENDER_PARTIAL_EN
   task automatic test_partial();
      logic [7:0] masks [3];
      bit ok;
      int d, dr;
      masks[0] = 8'b0000_0101;
      masks[1] = 8'h00;
      masks[2] = 8'($urandom);
      use_dut(1'b0);
      for (int k = 0; k < 3; k++) begin
         fill_fb(1'b0);
         clear_obs();
         build_expected(R1, C1, masks[k]);
         mask1 = masks[k];
         pulse_start();
         mask1 = ~masks[k];
         wait_done(40000, ok);
         repeat (4) @(negedge clk);
         d  = first_diff(rx_bytes, exp_bytes);
         dr = first_diff(reads, exp_reads);
         checks++;
         if (!ok || d !== -1 || dr !== -1 || dones !== 1 || rx_len.size() !== exp_len.size()) begin
            errors++;
            $display("FAIL partial_mask_%0h got ok=%0d diff=%0d rdiff=%0d dones=%0d frames=%0d want 1/-1/-1/1/%0d",
                     masks[k], ok, d, dr, dones, rx_len.size(), exp_len.size());
         end
      end
      mask1 = 8'hFF;
   endtask
`endif

   initial begin
      test_reset();
      test_full_frame();
      test_timing();
      test_start_held();
      test_back_to_back();
      test_reset_mid();
`ifdef SPI_FRAME_SENDER_PARTIAL_EN
      test_partial();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
